// File: rtl/pid_pwm_pkg.sv
// Shared types, constants and the per-period slew clamp for the PID PWM driver.
package pid_pwm_pkg;

    localparam int unsigned DUTY_W = 8;
    localparam logic [DUTY_W-1:0] CNT_MAX = 8'd254;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_t;

    // Move applied toward target by at most slew; 9-bit math so nothing wraps.
    function automatic logic [DUTY_W-1:0] slew_step(
        input logic [DUTY_W-1:0] applied,
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] slew
    );
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] down;
        up   = {1'b0, applied} + {1'b0, slew};
        down = {1'b0, applied} - {1'b0, slew};
        if ({1'b0, target} > up) begin
            return up[DUTY_W-1:0];
        end
        if ((applied >= slew) && ({1'b0, target} < down)) begin
            return down[DUTY_W-1:0];
        end
        return target;
    endfunction

endpackage

// File: rtl/pid_pwm_driver_tick_gen.sv
// PWM tick prescaler: one tick every PRESCALE clocks, held at zero while cleared.
module pwm_tick_gen #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

    assign tick = !clr && (count == LAST);

endmodule

// File: rtl/pid_pwm_driver.sv
// PID control word to single-pin PWM: boundary-synchronous duty update with slew limiting.
module pid_pwm_driver
    import pid_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned SLEW_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_applied,
    output logic              period_start,
    output logic              settled
);
    pwm_state_t        state;
    pwm_state_t        state_next;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] step;
    logic              idle;
    logic              tick;
    logic              wrap;
    logic              launch;
    logic              run_wrap;
    logic              stop_wrap;

    assign idle = (state == IDLE);
    assign wrap = tick && (cnt == CNT_MAX);
    assign step = slew_step(duty_applied, target, DUTY_W'(SLEW_MAX));

    pwm_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (idle),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A stopping driver that sees en again simply resumes; its wrap is then a normal run wrap.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        run_wrap   = 1'b0;
        stop_wrap  = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                    launch     = 1'b1;
                end
            end
            RUN: begin
                run_wrap = wrap;
                if (!en) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (en) begin
                    state_next = RUN;
                    run_wrap   = wrap;
                end else if (wrap) begin
                    state_next = IDLE;
                    stop_wrap  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target       <= '0;
            duty_applied <= '0;
            cnt          <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (duty_valid) begin
                target <= duty_in;
            end
            pwm_out      <= !idle && (cnt < duty_applied);
            period_start <= launch || run_wrap;
            if (launch || run_wrap) begin
                cnt          <= '0;
                duty_applied <= step;
            end else if (stop_wrap) begin
                cnt          <= '0;
                duty_applied <= '0;
            end else if (tick) begin
                cnt <= cnt + DUTY_W'(1);
            end
        end
    end

    assign settled = (duty_applied == target);

endmodule
